// File: rtl/ttl_74595_sipo_if.sv
// Control/status bundle of the 74595-style SIPO expander: shift/latch/enable
// controls towards the register, cascade bit, bit count and frame flag back.
interface ttl_74595_sipo_if #(
    parameter int WIDTH_OUT = 8
);
    localparam int CW = $clog2(WIDTH_OUT + 1);

    logic          Shift_en;
    logic          Serial_in;
    logic          Latch;
    logic          Output_en_bar;
    logic          Q_serial;
    logic [CW-1:0] Count;
    logic          Frame_ready;

    modport master (
        output Shift_en,
        output Serial_in,
        output Latch,
        output Output_en_bar,
        input  Q_serial,
        input  Count,
        input  Frame_ready
    );

    modport slave (
        input  Shift_en,
        input  Serial_in,
        input  Latch,
        input  Output_en_bar,
        output Q_serial,
        output Count,
        output Frame_ready
    );
endinterface

// File: rtl/ttl_74595_sipo.sv
// 74595-style serial-in/parallel-out register with storage stage, saturating bit count and tri-state Q.
// Latch shows on Q one edge later; TTL_74595_SIPO_AUTOLATCH_EN stores each completed word automatically.
module ttl_74595_sipo #(
    parameter int WIDTH_OUT  = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                 Clk,
    input  logic                 Clear,
    ttl_74595_sipo_if.slave      bus,
    output wire  [WIDTH_OUT-1:0] Q
);
    localparam int            CW         = $clog2(WIDTH_OUT + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH_OUT);
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH_OUT - 1);

    // Zero-delay model: edge timing is left to the implementation, only sanity is enforced here.
    generate
        if (WIDTH_OUT < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_cfg
            $error("ttl_74595_sipo: WIDTH_OUT must be >= 2 and delays non-negative");
        end
    endgenerate

    logic [WIDTH_OUT-1:0] r_shift;
    logic [WIDTH_OUT-1:0] r_store;
    logic [CW-1:0]        r_count;

    logic [WIDTH_OUT-1:0] w_shift_post;
    logic [WIDTH_OUT-1:0] w_shift_nxt;
    logic [WIDTH_OUT-1:0] w_store_nxt;
    logic [CW-1:0]        w_count_nxt;
    logic                 w_full;
    logic                 w_auto;

    assign w_shift_post = {r_shift[WIDTH_OUT-2:0], bus.Serial_in};
    assign w_full       = (r_count == COUNT_FULL);

`ifdef TTL_74595_SIPO_AUTOLATCH_EN
    assign w_auto = bus.Shift_en && (r_count == COUNT_LAST);
`else
    assign w_auto = 1'b0;
`endif

    always_comb begin
        w_shift_nxt = r_shift;
        w_store_nxt = r_store;
        w_count_nxt = r_count;

        if (bus.Shift_en) begin
            w_shift_nxt = w_shift_post;
        end

        // Auto-latch outranks an explicit Latch: the completed word is the useful one.
        if (w_auto) begin
            w_store_nxt = w_shift_post;
        end else if (bus.Latch) begin
            w_store_nxt = r_shift;
        end

        if (w_auto) begin
            w_count_nxt = '0;
        end else if (bus.Latch) begin
            w_count_nxt = bus.Shift_en ? CW'(1) : '0;
        end else if (bus.Shift_en && !w_full) begin
            w_count_nxt = r_count + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            r_shift <= '0;
            r_store <= '0;
            r_count <= '0;
        end else begin
            r_shift <= w_shift_nxt;
            r_store <= w_store_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign Q            = bus.Output_en_bar ? {WIDTH_OUT{1'bz}} : r_store;
    assign bus.Q_serial = r_shift[WIDTH_OUT-1];
    assign bus.Count    = r_count;

`ifdef TTL_74595_SIPO_AUTOLATCH_EN
    // Words are handed off on the completing edge, so the count never rests at full.
    assign bus.Frame_ready = 1'b0;
`else
    assign bus.Frame_ready = w_full;
`endif

endmodule

// File: tb/tb_ttl_74595_sipo.sv
// Directed vector bench for ttl_74595_sipo (8 outputs); the auto-latch stream
// sequence replaces the table when TTL_74595_SIPO_AUTOLATCH_EN is defined.
module tb_ttl_74595_sipo;
    localparam int W  = 8;
    localparam int CW = 4;

    logic Clk = 1'b0;
    logic Clear;
    wire [W-1:0] q_w;

    ttl_74595_sipo_if #(.WIDTH_OUT(W)) bus();

    ttl_74595_sipo #(
        .WIDTH_OUT (W),
        .DELAY_RISE(0),
        .DELAY_FALL(0)
    ) dut (
        .Clk  (Clk),
        .Clear(Clear),
        .bus  (bus),
        .Q    (q_w)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          clr;
        logic          sh;
        logic          si;
        logic          la;
        logic          oeb;
        logic [W-1:0]  q;
        logic          qz;
        logic          qs;
        logic [CW-1:0] cnt;
        logic          fr;
    } vec_t;

    vec_t tbl[64];
    int   n_vec  = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic clr, sh, si, la, oeb, input logic [W-1:0] q,
                       input logic qz, qs, input int cnt, input logic fr);
        tbl[n_vec].clr = clr;
        tbl[n_vec].sh  = sh;
        tbl[n_vec].si  = si;
        tbl[n_vec].la  = la;
        tbl[n_vec].oeb = oeb;
        tbl[n_vec].q   = q;
        tbl[n_vec].qz  = qz;
        tbl[n_vec].qs  = qs;
        tbl[n_vec].cnt = CW'(cnt);
        tbl[n_vec].fr  = fr;
        n_vec++;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input logic clr, sh, si, la, oeb);
        @(negedge Clk);
        Clear             = clr;
        bus.Shift_en      = sh;
        bus.Serial_in     = si;
        bus.Latch         = la;
        bus.Output_en_bar = oeb;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] word;
        Clear             = 1'b1;
        bus.Shift_en      = 1'b0;
        bus.Serial_in     = 1'b0;
        bus.Latch         = 1'b0;
        bus.Output_en_bar = 1'b0;

`ifndef TTL_74595_SIPO_AUTOLATCH_EN
        // Reset state
        add(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        // Frame 8'hB2, first bit first; Frame_ready on the 8th shift
        word = 8'hB2;
        for (int i = 0; i < 8; i++)
            add(0, 1, word[7-i], 0, 0, 8'h00, 0, (i == 7), i + 1, (i == 7));
        add(0, 0, 0, 1, 0, 8'hB2, 0, 1, 0, 0);
        // Three more bits without Latch: Q holds
        add(0, 1, 1, 0, 0, 8'hB2, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 8'hB2, 0, 1, 2, 0);
        add(0, 1, 0, 0, 0, 8'hB2, 0, 1, 3, 0);
        // Latch + Shift on one edge stores the pre-shift word 8'h96
        add(0, 1, 1, 1, 0, 8'h96, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h96, 0, 0, 1, 0);
        // Disabled outputs: Q is z, cascade keeps shifting
        add(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        word = 8'hC3;
        for (int i = 0; i < 8; i++)
            add(0, 1, word[7-i], 0, 1, 8'h00, 1, (i == 7), i + 1, (i == 7));
        add(0, 0, 0, 1, 1, 8'h00, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 8'hC3, 0, 1, 0, 0);
        // Partial frame of five ones, then Clear with Latch
        for (int i = 0; i < 5; i++)
            add(0, 1, 1, 0, 0, 8'hC3, 0, (i == 0), i + 1, 0);
        add(1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        // Saturation: nine shifts, Count sticks at 8
        for (int i = 0; i < 9; i++)
            add(0, 1, 1, 0, 0, 8'h00, 0, (i >= 7), (i >= 7) ? 8 : i + 1, (i >= 7));
        add(0, 0, 0, 1, 0, 8'hFF, 0, 1, 0, 0);

        for (int k = 0; k < n_vec; k++) begin
            step(tbl[k].clr, tbl[k].sh, tbl[k].si, tbl[k].la, tbl[k].oeb);
            if (tbl[k].qz) begin
                checks++;
                if (!(q_w === 8'bzzzzzzzz)) begin
                    errors++;
                    $display("FAIL q_hiz step %0d: got %b expected zzzzzzzz", k, q_w);
                end
            end else begin
                chk("q", k, 32'(q_w), 32'(tbl[k].q));
            end
            chk("q_serial", k, 32'(bus.Q_serial), 32'(tbl[k].qs));
            chk("count", k, 32'(bus.Count), 32'(tbl[k].cnt));
            chk("frame_ready", k, 32'(bus.Frame_ready), 32'(tbl[k].fr));
        end
`else
        begin
            logic [15:0]  stream;
            logic [W-1:0] exp_q;
            stream = 16'hA53C;
            exp_q  = 8'h00;
            step(1, 0, 0, 0, 0);
            chk("q", 0, 32'(q_w), 32'h0);
            chk("count", 0, 32'(bus.Count), 32'h0);
            for (int k = 1; k <= 16; k++) begin
                step(0, 1, stream[16-k], 0, 0);
                if (k == 8)  exp_q = 8'hA5;
                if (k == 16) exp_q = 8'h3C;
                chk("q", k, 32'(q_w), 32'(exp_q));
                chk("count", k, 32'(bus.Count), 32'(k % 8));
                chk("frame_ready", k, 32'(bus.Frame_ready), 32'h0);
                chk("q_serial", k, 32'(bus.Q_serial), (k < 8) ? 32'h0 : 32'(stream[16-(k-7)]));
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
